// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of (PC, instruction) pairs between the fetch and
// decode stages. It uses valid/ready handshakes on both sides and a synchronous
// flush for control-flow redirects. Reset is asynchronous and clears all state,
// including storage, so the head outputs read 0 after reset.
module fetch_queue #(
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 4
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic [D_WIDTH-1:0]           PCIn,
  input  logic [D_WIDTH-1:0]           InstrIn,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic                         Flush,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [D_WIDTH-1:0]           PCOut,
  output logic [D_WIDTH-1:0]           InstrOut,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count_reg;
  logic [D_WIDTH-1:0] pc_mem    [DEPTH];
  logic [D_WIDTH-1:0] instr_mem [DEPTH];
  logic               push;
  logic               pop;

  // Handshake flags come from registered occupancy only, so ready never
  // depends combinationally on the opposite side of the queue.
  assign InReady  = (count_reg != CW'(DEPTH));
  assign OutValid = (count_reg != '0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;
  assign Count    = count_reg;
  assign PCOut    = pc_mem[rd_ptr];
  assign InstrOut = instr_mem[rd_ptr];

  // One storage slot per entry. A flushed push is not stored. Flush leaves
  // the old contents in place; only reset clears them.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture the incoming pair when this slot is the write target.
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        pc_mem[gi]    <= '0;
        instr_mem[gi] <= '0;
      end else if (push && !Flush && (wr_ptr == PW'(gi))) begin
        pc_mem[gi]    <= PCIn;
        instr_mem[gi] <= InstrIn;
      end
    end
  end

  // Pointers and occupancy. Flush has priority and discards any handshake
  // in the same cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_reg <= '0;
    end else if (Flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule
